// File: rtl/tsen_seq_pkg.sv
// Shared types for the temperature-sensor poll sequencer: TL-UL structs,
// sensor register offsets, FSM states and request builders.
package tsen_seq_pkg;

    localparam logic [31:0] ADDR_SPACE_TSEN1 = 32'h4040_0000;

    localparam logic [11:0] TSEN_ENABLE_OFS = 12'h0C;
    localparam logic [11:0] TSEN_SEL_OFS    = 12'h10;
    localparam logic [11:0] TSEN_DONE_OFS   = 12'h14;

    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'h0;
    localparam logic [2:0] TL_GET             = 3'h4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'h0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam tl_h2d_t TL_H2D_DEFAULT = '0;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_EN, ST_WR_SEL, ST_RD_DONE, ST_RD_DATA, ST_WAIT, ST_WR_DIS
    } tsen_state_e;

    function automatic logic is_bus_state(input tsen_state_e st);
        return (st != ST_IDLE) && (st != ST_WAIT);
    endfunction

    function automatic tl_h2d_t tl_write(input logic [31:0] addr, input logic [31:0] data);
        tl_h2d_t pkt;
        pkt           = TL_H2D_DEFAULT;
        pkt.a_valid   = 1'b1;
        pkt.a_opcode  = TL_PUT_FULL_DATA;
        pkt.a_size    = 2'd2;
        pkt.a_mask    = 4'hf;
        pkt.a_address = addr;
        pkt.a_data    = data;
        pkt.d_ready   = 1'b1;
        return pkt;
    endfunction

    function automatic tl_h2d_t tl_read(input logic [31:0] addr);
        tl_h2d_t pkt;
        pkt           = tl_write(addr, 32'h0);
        pkt.a_opcode  = TL_GET;
        return pkt;
    endfunction

endpackage

// File: rtl/tsen_tl_req.sv
// Single-outstanding TL-UL host port: holds a request until a_ready,
// then waits for d_valid and hands the response back for one cycle.
module tsen_tl_req
    import tsen_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  tl_h2d_t     req_pkt_i,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);
    tl_h2d_t r_pkt;
    logic    r_pend;
    logic    w_unused_d;

    assign rsp_valid_o = r_pend && tl_i.d_valid;
    assign rsp_data_o  = tl_i.d_data;
    assign rsp_err_o   = tl_i.d_error;
    assign w_unused_d  = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink};

    always_comb begin
        tl_o         = r_pkt;
        tl_o.d_ready = 1'b1;
    end

    // A new request may be loaded in the same cycle the previous response lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pkt  <= TL_H2D_DEFAULT;
            r_pend <= 1'b0;
        end else begin
            if (r_pkt.a_valid && tl_i.a_ready) begin
                r_pkt.a_valid <= 1'b0;
                r_pend        <= 1'b1;
            end else if (rsp_valid_o) begin
                r_pend <= 1'b0;
            end
            if (req_i) begin
                r_pkt <= req_pkt_i;
            end
        end
    end

endmodule

// File: rtl/tsen_poll_sequencer.sv
// Autonomous TL-UL host that periodically enables, polls and reads the temperature sensor.
// state      | meaning
// IDLE       | stopped, waiting for enable_i
// WR_EN      | writing ENABLE=1
// WR_SEL     | writing sense-path select
// RD_DONE    | polling DONE
// RD_DATA    | reading temperature
// WAIT       | inter-measurement delay
// WR_DIS     | writing ENABLE=0 before stopping
module tsen_poll_sequencer
    import tsen_seq_pkg::*;
#(
    parameter logic [31:0] BaseAddr  = ADDR_SPACE_TSEN1,
    parameter int unsigned DataW     = 10,
    parameter int unsigned IntervalW = 16,
    parameter int unsigned MaxPolls  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 sel_i,
    input  logic [IntervalW-1:0] interval_i,
    input  logic [DataW-1:0]     threshold_i,
    input  logic                 alert_clr_i,
    output tl_h2d_t              tl_o,
    input  tl_d2h_t              tl_i,
    output logic [DataW-1:0]     temp_o,
    output logic                 temp_valid_o,
    output logic                 alert_o,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int unsigned PollW = $clog2(MaxPolls + 1);

    tsen_state_e          r_state, w_state_next, w_after;
    logic [PollW-1:0]     r_poll_cnt;
    logic [IntervalW-1:0] r_wait_cnt;
    logic [DataW-1:0]     r_temp;
    logic                 r_temp_valid, r_alert, r_err;
    logic                 w_req, w_reread, w_err_set, w_temp_load, w_alert_set;
    logic                 w_poll_clr, w_poll_inc, w_poll_last;
    logic                 w_rsp_valid, w_rsp_err, w_unused_rsp;
    logic [31:0]          w_rsp_data;
    tl_h2d_t              w_req_pkt;

    tsen_tl_req u_tl_req (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (w_req),
        .req_pkt_i   (w_req_pkt),
        .tl_o        (tl_o),
        .tl_i        (tl_i),
        .rsp_valid_o (w_rsp_valid),
        .rsp_data_o  (w_rsp_data),
        .rsp_err_o   (w_rsp_err)
    );

    assign w_after      = enable_i ? ST_WAIT : ST_WR_DIS;
    assign w_poll_last  = (r_poll_cnt == PollW'(MaxPolls - 1));
    assign w_alert_set  = w_temp_load && (w_rsp_data[DataW-1:0] > threshold_i);
    assign w_unused_rsp = ^w_rsp_data[31:DataW];

    always_comb begin
        w_state_next = r_state;
        w_reread     = 1'b0;
        w_err_set    = 1'b0;
        w_temp_load  = 1'b0;
        w_poll_clr   = 1'b0;
        w_poll_inc   = 1'b0;
        case (r_state)
            ST_IDLE: if (enable_i) w_state_next = ST_WR_EN;
            ST_WR_EN, ST_WR_SEL: if (w_rsp_valid) begin
                w_err_set  = w_rsp_err;
                w_poll_clr = 1'b1;
                if (!enable_i || w_rsp_err) w_state_next = w_after;
                else w_state_next = (r_state == ST_WR_EN) ? ST_WR_SEL : ST_RD_DONE;
            end
            ST_RD_DONE: if (w_rsp_valid) begin
                if (w_rsp_err) begin
                    w_err_set    = 1'b1;
                    w_state_next = w_after;
                end else if (w_rsp_data[0]) begin
                    w_state_next = enable_i ? ST_RD_DATA : ST_WR_DIS;
                end else begin
                    w_poll_inc = 1'b1;
                    if (w_poll_last) begin
                        w_err_set    = 1'b1;
                        w_state_next = w_after;
                    end else if (enable_i) begin
                        w_reread = 1'b1;
                    end else begin
                        w_state_next = ST_WR_DIS;
                    end
                end
            end
            ST_RD_DATA: if (w_rsp_valid) begin
                w_err_set    = w_rsp_err;
                w_temp_load  = !w_rsp_err;
                w_state_next = w_after;
            end
            ST_WAIT: begin
                if (!enable_i) w_state_next = ST_WR_DIS;
                else if (r_wait_cnt <= IntervalW'(1)) w_state_next = ST_WR_SEL;
            end
            ST_WR_DIS: if (w_rsp_valid) begin
                w_err_set    = w_rsp_err;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request is launched on the transition into a bus state (or a DONE re-poll).
    always_comb begin
        w_req = is_bus_state(w_state_next) && ((w_state_next != r_state) || w_reread);
        case (w_state_next)
            ST_WR_EN:   w_req_pkt = tl_write(BaseAddr + {20'h0, TSEN_ENABLE_OFS}, 32'h1);
            ST_WR_SEL:  w_req_pkt = tl_write(BaseAddr + {20'h0, TSEN_SEL_OFS}, {31'h0, sel_i});
            ST_RD_DONE: w_req_pkt = tl_read(BaseAddr + {20'h0, TSEN_DONE_OFS});
            ST_RD_DATA: w_req_pkt = tl_read(BaseAddr + {20'h0, TSEN_SEL_OFS});
            ST_WR_DIS:  w_req_pkt = tl_write(BaseAddr + {20'h0, TSEN_ENABLE_OFS}, 32'h0);
            default:    w_req_pkt = TL_H2D_DEFAULT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_poll_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_temp       <= '0;
            r_temp_valid <= 1'b0;
            r_alert      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_poll_clr) r_poll_cnt <= '0;
            else if (w_poll_inc) r_poll_cnt <= r_poll_cnt + PollW'(1);
            if ((w_state_next == ST_WAIT) && (r_state != ST_WAIT)) r_wait_cnt <= interval_i;
            else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) r_wait_cnt <= r_wait_cnt - IntervalW'(1);
            r_temp_valid <= w_temp_load;
            if (w_temp_load) r_temp <= w_rsp_data[DataW-1:0];
            if (w_alert_set) r_alert <= 1'b1;
            else if (alert_clr_i) r_alert <= 1'b0;
            if (w_err_set) r_err <= 1'b1;
            else if (alert_clr_i) r_err <= 1'b0;
        end
    end

    assign temp_o       = r_temp;
    assign temp_valid_o = r_temp_valid;
    assign alert_o      = r_alert;
    assign err_o        = r_err;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tsen_poll_sequencer.sv
// Scoreboard bench: stimulus queues expected bus transfers and temperatures,
// a device model/monitor pops and compares them as the DUT produces them.
module tb_tsen_poll_sequencer;
    import tsen_seq_pkg::*;

    localparam logic [31:0] BASE = 32'h4040_0000;

    logic        clk = 1'b0;
    logic        rst, enable, sel, alert_clr;
    logic [15:0] interval;
    logic [9:0]  threshold, temp;
    logic        temp_valid, alert, busy, err;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h;

    always #5 clk = ~clk;

    tsen_poll_sequencer #(.BaseAddr(BASE), .DataW(10), .IntervalW(16), .MaxPolls(4)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .sel_i(sel), .interval_i(interval),
        .threshold_i(threshold), .alert_clr_i(alert_clr), .tl_o(tl_h2d), .tl_i(tl_d2h),
        .temp_o(temp), .temp_valid_o(temp_valid), .alert_o(alert), .busy_o(busy), .err_o(err)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_exp_t;

    int          total_cnt = 0, pass_cnt = 0;
    bus_exp_t    exp_bus[$];
    int          exp_temp[$];
    logic [31:0] done_q[$];
    logic [31:0] data_val = 0;
    logic        err_on_data = 0;
    int          stall_cnt = 0, tv_cnt = 0, cyc = 0, t_data = 0, last_gap = -1;
    logic        acc_prev = 0, stalling = 0;
    tl_h2d_t     acc_pkt, held;
    bus_exp_t    mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_w(input logic [11:0] ofs, input logic [31:0] d);
        bus_exp_t e;
        e.we = 1'b1; e.addr = BASE + {20'h0, ofs}; e.data = d;
        exp_bus.push_back(e);
    endtask

    task automatic push_r(input logic [11:0] ofs);
        bus_exp_t e;
        e.we = 1'b0; e.addr = BASE + {20'h0, ofs}; e.data = 0;
        exp_bus.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_tv(input string name, input int n);
        for (int i = 0; i < 200; i++) begin
            if (tv_cnt >= n) return;
            tick(1);
        end
        chk({"timeout_", name}, tv_cnt, n);
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_bus.size() == 0) return;
            tick(1);
        end
        chk({"timeout_", name}, exp_bus.size(), 0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy && exp_bus.size() == 0) return;
            tick(1);
        end
        chk({"timeout_", name}, {busy, 31'(exp_bus.size())}, 0);
    endtask

    task automatic pulse_clr();
        alert_clr = 1'b1;
        tick(1);
        alert_clr = 1'b0;
        tick(1);
    endtask

    task automatic measure_seq(input logic s);
        push_w(TSEN_ENABLE_OFS, 1);
        push_w(TSEN_SEL_OFS, {31'h0, s});
        push_r(TSEN_DONE_OFS);
        push_r(TSEN_SEL_OFS);
    endtask

    // Device model + monitor: zero-wait responder with optional a_ready stall.
    always @(negedge clk) begin
        cyc++;
        tl_d2h.d_valid  = 1'b0;
        tl_d2h.d_error  = 1'b0;
        tl_d2h.d_data   = 32'h0;
        tl_d2h.d_opcode = TL_ACCESS_ACK;
        tl_d2h.d_size   = 2'd2;
        if (rst) begin
            acc_prev = 1'b0;
            stalling = 1'b0;
        end
        if (acc_prev) begin
            tl_d2h.d_valid = 1'b1;
            if (acc_pkt.a_opcode == TL_GET) begin
                tl_d2h.d_opcode = TL_ACCESS_ACK_DATA;
                if (acc_pkt.a_address == BASE + 32'h14) begin
                    tl_d2h.d_data = (done_q.size() != 0) ? done_q.pop_front() : 32'h1;
                end else if (err_on_data) begin
                    tl_d2h.d_error = 1'b1;
                    tl_d2h.d_data  = 32'd999;
                    err_on_data    = 1'b0;
                end else begin
                    tl_d2h.d_data = data_val;
                    t_data        = cyc;
                end
            end
        end
        acc_prev = 1'b0;
        if (stall_cnt > 0 && (stalling || tl_h2d.a_valid)) begin
            if (stalling) begin
                chk("stall_a_valid", tl_h2d.a_valid, 1);
                chk("stall_addr", tl_h2d.a_address, held.a_address);
                chk("stall_data", tl_h2d.a_data, held.a_data);
            end else begin
                held = tl_h2d;
            end
            stalling       = 1'b1;
            tl_d2h.a_ready = 1'b0;
            stall_cnt--;
        end else begin
            stalling       = 1'b0;
            tl_d2h.a_ready = 1'b1;
            if (tl_h2d.a_valid) begin
                acc_prev = 1'b1;
                acc_pkt  = tl_h2d;
                if (tl_h2d.a_opcode == TL_PUT_FULL_DATA && tl_h2d.a_address == BASE + 32'h10)
                    last_gap = cyc - t_data;
                if (exp_bus.size() == 0) begin
                    total_cnt++;
                    $display("FAIL bus_unexpected: got addr %0h op %0h, expected no transfer",
                             tl_h2d.a_address, tl_h2d.a_opcode);
                end else begin
                    mon_e = exp_bus.pop_front();
                    chk("bus_addr", tl_h2d.a_address, mon_e.addr);
                    chk("bus_opcode", 32'(tl_h2d.a_opcode), mon_e.we ? 32'(TL_PUT_FULL_DATA) : 32'(TL_GET));
                    chk("bus_mask_size", {tl_h2d.a_mask, tl_h2d.a_size, tl_h2d.a_source}, {4'hf, 2'd2, 8'h0});
                    if (mon_e.we) chk("bus_wdata", tl_h2d.a_data, mon_e.data);
                end
            end
        end
        if (temp_valid) begin
            tv_cnt++;
            if (exp_temp.size() == 0) begin
                total_cnt++;
                $display("FAIL temp_unexpected: got temp_valid with %0d, expected none", temp);
            end else begin
                chk("temp_o", temp, exp_temp.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int tv0;
        tl_d2h = '0;
        rst = 1'b1; enable = 1'b0; sel = 1'b1; alert_clr = 1'b0;
        interval = 16'd1000; threshold = 10'd1023;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", tl_h2d.a_valid, 0);
        chk("rst_d_ready", tl_h2d.d_ready, 1);
        chk("rst_temp", temp, 0);
        chk("rst_temp_valid", temp_valid, 0);
        chk("rst_flags", {alert, busy, err}, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // basic measurement
        data_val = 69;
        measure_seq(1'b1);
        exp_temp.push_back(69);
        tv0 = tv_cnt;
        enable = 1'b1;
        wait_tv("t1", tv0 + 1);
        tick(10);
        chk("t1_pulses", tv_cnt - tv0, 1);
        chk("t1_temp_hold", temp, 69);
        chk("t1_alert_err", {alert, err}, 0);
        enable = 1'b0;
        push_w(TSEN_ENABLE_OFS, 0);
        wait_idle("t1_stop");

        // alert set / clear / re-set
        threshold = 10'd60;
        measure_seq(1'b1);
        exp_temp.push_back(69);
        enable = 1'b1;
        wait_tv("t2a", tv_cnt + 1);
        tick(1);
        chk("t2_alert_set", alert, 1);
        tick(5);
        chk("t2_alert_sticky", alert, 1);
        pulse_clr();
        chk("t2_alert_clr", alert, 0);
        enable = 1'b0;
        push_w(TSEN_ENABLE_OFS, 0);
        wait_idle("t2_stop1");
        measure_seq(1'b1);
        exp_temp.push_back(69);
        enable = 1'b1;
        wait_tv("t2b", tv_cnt + 1);
        tick(1);
        chk("t2_alert_reset", alert, 1);
        enable = 1'b0;
        push_w(TSEN_ENABLE_OFS, 0);
        wait_idle("t2_stop2");
        pulse_clr();

        // DONE polling: success on 4th read, then timeout after 4 reads
        threshold = 10'd1023; sel = 1'b0; data_val = 300;
        done_q = '{0, 0, 0, 1};
        push_w(TSEN_ENABLE_OFS, 1); push_w(TSEN_SEL_OFS, 0);
        repeat (4) push_r(TSEN_DONE_OFS);
        push_r(TSEN_SEL_OFS);
        exp_temp.push_back(300);
        enable = 1'b1;
        wait_tv("t3a", tv_cnt + 1);
        chk("t3_no_err", err, 0);
        enable = 1'b0;
        push_w(TSEN_ENABLE_OFS, 0);
        wait_idle("t3_stop1");
        done_q = '{0, 0, 0, 0};
        push_w(TSEN_ENABLE_OFS, 1); push_w(TSEN_SEL_OFS, 0);
        repeat (4) push_r(TSEN_DONE_OFS);
        tv0 = tv_cnt;
        enable = 1'b1;
        wait_drained("t3b");
        tick(10);
        chk("t3_timeout_err", err, 1);
        chk("t3_no_temp", tv_cnt - tv0, 0);
        chk("t3_reads_used", done_q.size(), 0);
        enable = 1'b0;
        push_w(TSEN_ENABLE_OFS, 0);
        wait_idle("t3_stop2");
        pulse_clr();
        chk("t3_err_clr", err, 0);

        // a_ready stall with enable dropped mid-request
        stall_cnt = 5;
        push_w(TSEN_ENABLE_OFS, 1);
        push_w(TSEN_ENABLE_OFS, 0);
        tv0 = tv_cnt;
        enable = 1'b1;
        tick(2);
        enable = 1'b0;
        wait_idle("t4");
        chk("t4_stall_used", stall_cnt, 0);
        chk("t4_no_temp", tv_cnt - tv0, 0);

        // WAIT interval timing: 10 and 0
        for (int k = 0; k < 2; k++) begin
            interval = (k == 0) ? 16'd10 : 16'd0;
            data_val = 5;
            measure_seq(1'b0);
            push_w(TSEN_SEL_OFS, 0); push_r(TSEN_DONE_OFS); push_r(TSEN_SEL_OFS);
            exp_temp.push_back(5); exp_temp.push_back(5);
            tv0 = tv_cnt;
            enable = 1'b1;
            wait_tv("t5a", tv0 + 1);
            interval = 16'd1000;
            wait_tv("t5b", tv0 + 2);
            chk((k == 0) ? "t5_gap_10" : "t5_gap_0", last_gap, (k == 0) ? 11 : 2);
            enable = 1'b0;
            push_w(TSEN_ENABLE_OFS, 0);
            wait_idle("t5_stop");
        end

        // d_error on DATA read
        err_on_data = 1'b1;
        measure_seq(1'b0);
        tv0 = tv_cnt;
        enable = 1'b1;
        wait_drained("t6b");
        tick(5);
        chk("t6_derr_err", err, 1);
        chk("t6_derr_temp", temp, 5);
        chk("t6_derr_no_pulse", tv_cnt - tv0, 0);
        enable = 1'b0;
        push_w(TSEN_ENABLE_OFS, 0);
        wait_idle("t6b_stop");

        // reset while DONE read is on the bus
        push_w(TSEN_ENABLE_OFS, 1); push_w(TSEN_SEL_OFS, 0); push_r(TSEN_DONE_OFS);
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (tl_h2d.a_valid && tl_h2d.a_address == BASE + 32'h14) break;
            tick(1);
        end
        chk("t6_rd_done_seen", {tl_h2d.a_valid, tl_h2d.a_address}, {1'b1, BASE + 32'h14});
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_a_valid", tl_h2d.a_valid, 0);
        chk("t6_rst_temp", temp, 0);
        chk("t6_rst_flags", {temp_valid, alert, busy, err, tl_h2d.d_ready}, 1);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("t6_idle_after", busy, 0);
        chk("t6_bus_empty", exp_bus.size(), 0);
        chk("end_temp_q", exp_temp.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
